// File: rtl/iob_eth_buf_mem_pkg.sv
// Purpose : shared types and derived constants for the Ethernet frame-buffer memory.
// Latency : n/a (types, constants and helper functions only).
// Backpr. : n/a.
package iob_eth_buf_pkg;

  // Arbiter / response FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESP_WB  = 2'd1,
    ST_RESP_IOB = 2'd2,
    ST_ERR_WB   = 2'd3
  } state_t;

  // Identity of the master that last owned the RAM.
  typedef enum logic {
    GNT_WB  = 1'b0,
    GNT_IOB = 1'b1
  } grant_t;

  // Default buffer geometry: 2048 words = 8 KiB.
  localparam int DEF_BUF_AW = 11;
  localparam int BUF_BYTES  = 2 ** (DEF_BUF_AW + 2);

  // The Wishbone window compare covers every address bit above the buffer.
  localparam int WIN_MSB = 31;

  function automatic int win_lsb(input int aw);
    return aw + 2;
  endfunction

  function automatic int buf_bytes(input int aw);
    return 2 ** (aw + 2);
  endfunction

endpackage

// File: rtl/iob_eth_buf_mem_spram.sv
// Purpose : single-port synchronous RAM with byte enables, 2^AW x DW, no reset.
// Latency : read data on dout one cycle after an enabled access.
// Backpr. : none; accepts one access per enabled cycle.
// Ports   : clk; en/we/be/addr/din access request; dout registered read data.
module iob_eth_spram #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++) begin
          if (be[i]) r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
      r_dout <= r_mem[addr];
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/iob_eth_buf_mem.sv
// Purpose : frame buffer shared by the MAC Wishbone DMA master and the CPU IOb port.
// Latency : grant in cycle N, ack/err/ready in N+1; each port at most one access per 2 cycles.
// Backpr. : requests are held by the masters until terminated; fair alternation under contention.
// Ports   : clk, rst (async active-low); IOb valid/address/wdata/wstrb -> rdata/ready;
//           Wishbone slave wb_adr_i/wb_sel_i/wb_we_i/wb_dat_i/wb_cyc_i/wb_stb_i -> wb_dat_o/wb_ack_o/wb_err_o.
module iob_eth_buf_mem
  import iob_eth_buf_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 32,
  parameter int          BUF_AW  = 11,
  parameter logic [31:0] WB_BASE = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [31:0]         wb_adr_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam int WIN_LSB = win_lsb(BUF_AW);

  state_t              r_state, w_state_nxt;
  grant_t              r_last_grant, w_last_nxt;
  logic                r_iob_rd, w_iob_rd_nxt;
  logic [DATA_W-1:0]   r_rdata;
  logic [31:0]         r_wb_dat;

  logic                w_wb_req, w_iob_req, w_wb_hit;
  logic [BUF_AW-1:0]   w_wb_word, w_iob_word;
  logic                w_ram_en, w_ram_we;
  logic [DATA_W/8-1:0] w_ram_be;
  logic [BUF_AW-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_din, w_ram_dout;
  logic                w_unused;

  assign w_wb_req   = wb_cyc_i & wb_stb_i;
  assign w_iob_req  = valid;
  assign w_wb_hit   = (wb_adr_i[WIN_MSB:WIN_LSB] == WB_BASE[WIN_MSB:WIN_LSB]);
  assign w_wb_word  = wb_adr_i[BUF_AW+1:2];
  // IOb upper address bits are dropped, so the buffer aliases across the IOb space.
  assign w_iob_word = address[BUF_AW+1:2];
  assign w_unused   = ^{address[ADDR_W-1:BUF_AW+2], address[1:0], wb_adr_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_IOB;
      r_iob_rd     <= 1'b0;
      r_rdata      <= '0;
      r_wb_dat     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_iob_rd     <= w_iob_rd_nxt;
      if (r_state == ST_RESP_IOB && r_iob_rd) r_rdata <= w_ram_dout;
      if (r_state == ST_RESP_WB) r_wb_dat <= w_ram_dout;
    end
  end

  // Read data is live from the RAM in the response cycle and held afterwards.
  assign rdata    = (r_state == ST_RESP_IOB && r_iob_rd) ? w_ram_dout : r_rdata;
  assign wb_dat_o = (r_state == ST_RESP_WB) ? w_ram_dout : r_wb_dat;

  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last_grant;
    w_iob_rd_nxt = r_iob_rd;
    w_ram_en     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_be     = '0;
    w_ram_addr   = '0;
    w_ram_din    = '0;
    ready        = 1'b0;
    wb_ack_o     = 1'b0;
    wb_err_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // With both requesting, the master that did not go last wins.
        if (w_wb_req && (!w_iob_req || r_last_grant == GNT_IOB)) begin
          w_last_nxt = GNT_WB;
          if (w_wb_hit) begin
            w_ram_en    = 1'b1;
            w_ram_we    = wb_we_i;
            w_ram_be    = wb_sel_i;
            w_ram_addr  = w_wb_word;
            w_ram_din   = wb_dat_i;
            w_state_nxt = ST_RESP_WB;
          end else begin
            w_state_nxt = ST_ERR_WB;
          end
        end else if (w_iob_req) begin
          w_last_nxt   = GNT_IOB;
          w_ram_en     = 1'b1;
          w_ram_we     = |wstrb;
          w_ram_be     = wstrb;
          w_ram_addr   = w_iob_word;
          w_ram_din    = wdata;
          w_iob_rd_nxt = ~|wstrb;
          w_state_nxt  = ST_RESP_IOB;
        end
      end
      // A master that dropped cyc/stb gets no termination; a write is already in RAM.
      ST_RESP_WB: begin
        wb_ack_o    = w_wb_req;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR_WB: begin
        wb_err_o    = w_wb_req;
        w_state_nxt = ST_IDLE;
      end
      ST_RESP_IOB: begin
        ready       = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  iob_eth_spram #(
    .AW (BUF_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (w_ram_en),
    .we   (w_ram_we),
    .be   (w_ram_be),
    .addr (w_ram_addr),
    .din  (w_ram_din),
    .dout (w_ram_dout)
  );

endmodule

// File: tb/tb_iob_eth_buf_mem.sv
module tb_iob_eth_buf_mem;

  localparam logic [31:0] WB_BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_err_o;

  iob_eth_buf_mem #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .BUF_AW  (11),
    .WB_BASE (WB_BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .address  (address),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o)
  );

  always #5 clk = ~clk;

  // Expected termination: cycle it must appear in, err vs ack, and data to check.
  typedef struct {
    int          cyc;
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t wb_q[$];
  exp_t iob_q[$];
  exp_t wb_e, iob_e;

  int checks  = 0;
  int errors  = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compares every DUT termination against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ready !== 1'b0 || wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 ||
          rdata !== 32'h0 || wb_dat_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b ack=%b err=%b rdata=%h wb_dat_o=%h, required all zero",
                 ready, wb_ack_o, wb_err_o, rdata, wb_dat_o);
      end
    end else begin
      if (wb_ack_o || wb_err_o) begin
        checks++;
        if (wb_ack_o && wb_err_o) begin
          errors++;
          $display("FAIL ack_err_excl: ack=1 err=1 at cycle %0d, required not both", cyc_cnt);
        end
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: ack=%b err=%b at cycle %0d, required none", wb_ack_o, wb_err_o, cyc_cnt);
        end else begin
          wb_e = wb_q.pop_front();
          checks++;
          if (cyc_cnt != wb_e.cyc || wb_err_o !== wb_e.err) begin
            errors++;
            $display("FAIL wb_term: cycle %0d err=%b, required cycle %0d err=%b",
                     cyc_cnt, wb_err_o, wb_e.cyc, wb_e.err);
          end
          if (wb_e.chk) begin
            checks++;
            if (wb_dat_o !== wb_e.dat) begin
              errors++;
              $display("FAIL wb_data: got %h, required %h", wb_dat_o, wb_e.dat);
            end
          end
        end
      end else if (wb_q.size() != 0 && wb_q[0].cyc < cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL wb_timeout: no termination by cycle %0d, required at %0d", cyc_cnt, wb_q[0].cyc);
        void'(wb_q.pop_front());
      end

      if (ready) begin
        if (iob_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL iob_unexpected: ready=1 at cycle %0d, required none", cyc_cnt);
        end else begin
          iob_e = iob_q.pop_front();
          checks++;
          if (cyc_cnt != iob_e.cyc) begin
            errors++;
            $display("FAIL iob_latency: ready at cycle %0d, required %0d", cyc_cnt, iob_e.cyc);
          end
          if (iob_e.chk) begin
            checks++;
            if (rdata !== iob_e.dat) begin
              errors++;
              $display("FAIL iob_data: got %h, required %h", rdata, iob_e.dat);
            end
          end
        end
      end else if (iob_q.size() != 0 && iob_q[0].cyc < cyc_cnt) begin
        checks++;
        errors++;
        $display("FAIL iob_timeout: no ready by cycle %0d, required at %0d", cyc_cnt, iob_q[0].cyc);
        void'(iob_q.pop_front());
      end
    end
  end

  task automatic iob_op(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic chk, input logic [31:0] ed);
    @(posedge clk); #1;
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    iob_q.push_back('{cyc_cnt + 1, 1'b0, chk, ed});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    @(posedge clk); #1;
    valid = 1'b0; wstrb = '0;
  endtask

  task automatic wb_op(input logic [31:0] a, input logic we, input logic [3:0] sel,
                       input logic [31:0] d, input logic err, input logic chk,
                       input logic [31:0] ed);
    @(posedge clk); #1;
    wb_adr_i = a; wb_we_i = we; wb_sel_i = sel; wb_dat_i = d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wb_q.push_back('{cyc_cnt + 1, err, chk, ed});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) break;
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic IOb write then read.
    iob_op(16'h0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    iob_op(16'h0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF);

    // Partial Wishbone write over an IOb-written word.
    iob_op(16'h0020, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    wb_op(WB_BASE + 32'h20, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    iob_op(16'h0020, 32'h0, 4'h0, 1'b1, 32'hFFFF_5678);

    // Zero select write is acked but changes nothing; zero-strobe IOb is a read.
    wb_op(WB_BASE + 32'h20, 1'b1, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    iob_op(16'h0020, 32'h0000_0000, 4'h0, 1'b1, 32'hFFFF_5678);
    wb_op(WB_BASE + 32'h20, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_5678);

    // Out-of-window accesses terminate with err and leave RAM untouched.
    wb_op(WB_BASE + 32'h8000, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    wb_op(WB_BASE + 32'h8010, 1'b1, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    iob_op(16'h0010, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);

    // IOb aliasing modulo 8 KiB.
    iob_op(16'h2004, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
    iob_op(16'h0004, 32'h0, 4'h0, 1'b1, 32'hA5A5_A5A5);
    wb_op(WB_BASE + 32'h04, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA5A5_A5A5);

    // Reset, then both masters request together and keep requesting.
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    valid = 1'b1; address = 16'h0010; wstrb = 4'h0;
    wb_adr_i = WB_BASE + 32'h10; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wb_q.push_back('{cyc_cnt + 1, 1'b0, 1'b1, 32'hDEAD_BEEF});
    wb_q.push_back('{cyc_cnt + 5, 1'b0, 1'b1, 32'hDEAD_BEEF});
    iob_q.push_back('{cyc_cnt + 3, 1'b0, 1'b1, 32'hDEAD_BEEF});
    iob_q.push_back('{cyc_cnt + 7, 1'b0, 1'b1, 32'hDEAD_BEEF});
    repeat (8) @(posedge clk);
    #1;
    valid = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    // Reset while a Wishbone response is being presented.
    @(posedge clk); #1;
    wb_adr_i = WB_BASE + 32'h20; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    wb_op(WB_BASE + 32'h20, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 32'hFFFF_5678);

    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
